// File: rtl/dual_priority_pkg.sv
// dual_priority_pkg: shared constants, FSM state type and code range helper
// for the dual grant decoder.
//   N_REQ         number of request/grant lines
//   IDX_W         width of the 1-based index codes (2**IDX_W > N_REQ)
//   state_t       decoder FSM states
//   code_in_range 1 when a code is 0..N_REQ (0 = no request)
package dual_priority_pkg;

  localparam int N_REQ = 12;
  localparam int IDX_W = 4;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    GRANT_FIRST  = 2'd1,
    GRANT_SECOND = 2'd2
  } state_t;

  function automatic logic code_in_range(input logic [IDX_W-1:0] code);
    return (code <= IDX_W'(N_REQ));
  endfunction

endpackage

// File: rtl/index_decoder.sv
// index_decoder: combinational 1-based index code to one-hot grant vector.
// Ports:
//   code    in  IDX_W  1..N_REQ selects line code-1; 0 = none
//   onehot  out N_REQ  decoded grant vector (all zero for 0 or out of range)
//   invalid out 1      code is above N_REQ
module index_decoder
  import dual_priority_pkg::*;
(
  input  logic [IDX_W-1:0] code,
  output logic [N_REQ-1:0] onehot,
  output logic             invalid
);

  // Decode the code to a single line; out-of-range codes never match a line.
  always_comb begin
    onehot  = {N_REQ{1'b0}};
    invalid = !code_in_range(code);
    for (int i = 0; i < N_REQ; i++) begin
      if (code == IDX_W'(i + 1)) begin
        onehot[i] = 1'b1;
      end else begin
        onehot[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/dual_grant_decoder.sv
// dual_grant_decoder: turns a (first, second) index pair from the dual
// priority encoder into one-hot grants, issued one at a time over a
// grant/ack handshake after a valid/ready accept.
// Build option: define DUAL_GRANT_DECODER_MERGE_EN to present both grants
// together as a single two-hot grant acknowledged once.
// Ports:
//   clk_i         in  1      clock, rising edge
//   rst_i         in  1      synchronous active-high reset
//   first_i       in  IDX_W  first index (0 = none)
//   second_i      in  IDX_W  second index (0 = none)
//   valid_i       in  1      pair valid
//   ready_o       out 1      pair can be accepted (IDLE only)
//   grant_o       out N_REQ  registered grant vector
//   grant_valid_o out 1      grant_o is presented
//   grant_ack_i   in  1      consumer accepts current grant
//   done_o        out 1      one-cycle pulse after the pair completes
//   err_o         out 1      sticky: an out-of-range code was accepted
module dual_grant_decoder
  import dual_priority_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [IDX_W-1:0] first_i,
  input  logic [IDX_W-1:0] second_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [N_REQ-1:0] grant_o,
  output logic             grant_valid_o,
  input  logic             grant_ack_i,
  output logic             done_o,
  output logic             err_o
);

  state_t           state, state_n;
  logic [N_REQ-1:0] grant, grant_n;
  logic [N_REQ-1:0] pend, pend_n;     // second grant waiting behind the first
  logic             gvalid, gvalid_n;
  logic             done, done_n;
  logic             err, err_n;

  logic [N_REQ-1:0] first_vec, second_raw, second_vec;
  logic             first_inv, second_inv;
  logic             accept;

  index_decoder u_dec_first (
    .code    (first_i),
    .onehot  (first_vec),
    .invalid (first_inv)
  );

  index_decoder u_dec_second (
    .code    (second_i),
    .onehot  (second_raw),
    .invalid (second_inv)
  );

  // A duplicate of the first code would grant the same line twice, so drop it.
  assign second_vec = (second_i == first_i) ? {N_REQ{1'b0}} : second_raw;
  assign ready_o    = (state == IDLE);
  assign accept     = valid_i && ready_o;

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      grant  <= {N_REQ{1'b0}};
      pend   <= {N_REQ{1'b0}};
      gvalid <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_n;
      grant  <= grant_n;
      pend   <= pend_n;
      gvalid <= gvalid_n;
      done   <= done_n;
      err    <= err_n;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n  = state;
    grant_n  = grant;
    pend_n   = pend;
    gvalid_n = gvalid;
    done_n   = 1'b0;
    err_n    = err | (accept & (first_inv | second_inv));
    case (state)
      IDLE: begin
        if (valid_i) begin
`ifdef DUAL_GRANT_DECODER_MERGE_EN
          if ((first_vec | second_vec) != {N_REQ{1'b0}}) begin
            state_n  = GRANT_FIRST;
            grant_n  = first_vec | second_vec;
            pend_n   = {N_REQ{1'b0}};
            gvalid_n = 1'b1;
          end else begin
            done_n   = 1'b1;
          end
`else
          if (first_vec != {N_REQ{1'b0}}) begin
            state_n  = GRANT_FIRST;
            grant_n  = first_vec;
            pend_n   = second_vec;
            gvalid_n = 1'b1;
          end else if (second_vec != {N_REQ{1'b0}}) begin
            state_n  = GRANT_SECOND;
            grant_n  = second_vec;
            pend_n   = {N_REQ{1'b0}};
            gvalid_n = 1'b1;
          end else begin
            done_n   = 1'b1;
          end
`endif
        end else begin
          state_n = IDLE;
        end
      end
      GRANT_FIRST: begin
        if (grant_ack_i) begin
          if (pend != {N_REQ{1'b0}}) begin
            // Hand over to the second grant on the same edge: no bubble.
            state_n = GRANT_SECOND;
            grant_n = pend;
            pend_n  = {N_REQ{1'b0}};
          end else begin
            state_n  = IDLE;
            grant_n  = {N_REQ{1'b0}};
            gvalid_n = 1'b0;
            done_n   = 1'b1;
          end
        end else begin
          state_n = GRANT_FIRST;
        end
      end
      GRANT_SECOND: begin
        if (grant_ack_i) begin
          state_n  = IDLE;
          grant_n  = {N_REQ{1'b0}};
          gvalid_n = 1'b0;
          done_n   = 1'b1;
        end else begin
          state_n = GRANT_SECOND;
        end
      end
      default: begin
        state_n  = IDLE;
        grant_n  = {N_REQ{1'b0}};
        pend_n   = {N_REQ{1'b0}};
        gvalid_n = 1'b0;
      end
    endcase
  end

  assign grant_o       = grant;
  assign grant_valid_o = gvalid;
  assign done_o        = done;
  assign err_o         = err;

endmodule

// File: tb/tb_dual_grant_decoder.sv
// tb_dual_grant_decoder: scoreboard bench for dual_grant_decoder. Expected
// grants for each pair are queued when the pair is driven and popped as the
// DUT presents them. Define DUAL_GRANT_DECODER_MERGE_EN for the merged build.
module tb_dual_grant_decoder;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [3:0]  first_i;
  logic [3:0]  second_i;
  logic        valid_i;
  logic        ready_o;
  logic [11:0] grant_o;
  logic        grant_valid_o;
  logic        grant_ack_i;
  logic        done_o;
  logic        err_o;

  int total = 0;
  int bad   = 0;
  logic [11:0] exp_q[$];
  logic        exp_err;

  dual_grant_decoder dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .first_i       (first_i),
    .second_i      (second_i),
    .valid_i       (valid_i),
    .ready_o       (ready_o),
    .grant_o       (grant_o),
    .grant_valid_o (grant_valid_o),
    .grant_ack_i   (grant_ack_i),
    .done_o        (done_o),
    .err_o         (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] onehot(input int c);
    logic [11:0] one;
    one = 12'h001;
    if (c >= 1 && c <= 12) return one << (c - 1);
    return 12'h000;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Model the grants a pair should produce and push them to the scoreboard.
  task automatic push_expected(input int f, input int s);
    logic [11:0] fv, sv;
    fv = onehot(f);
    sv = (s == f) ? 12'h000 : onehot(s);
    if (f > 12 || s > 12) exp_err = 1'b1;
`ifdef DUAL_GRANT_DECODER_MERGE_EN
    if ((fv | sv) != 12'h000) exp_q.push_back(fv | sv);
`else
    if (fv != 12'h000) exp_q.push_back(fv);
    if (sv != 12'h000) exp_q.push_back(sv);
`endif
  endtask

  // Drive one pair, then consume every queued grant with ack_dly idle cycles.
  task automatic run_pair(input int f, input int s, input int ack_dly);
    logic [11:0] exp_g;
    push_expected(f, s);
    first_i  = 4'(f);
    second_i = 4'(s);
    valid_i  = 1'b1;
    tick();
    valid_i  = 1'b0;
    check_eq("err", err_o, exp_err);
    if (exp_q.size() == 0) begin
      check_eq("null_gvalid", grant_valid_o, 1'b0);
      check_eq("null_done", done_o, 1'b1);
      check_eq("null_ready", ready_o, 1'b1);
      tick();
      check_eq("null_done_end", done_o, 1'b0);
    end else begin
      while (exp_q.size() != 0) begin
        exp_g = exp_q.pop_front();
        check_eq("gvalid", grant_valid_o, 1'b1);
        check_eq("grant", grant_o, exp_g);
        check_eq("ready_busy", ready_o, 1'b0);
        check_eq("done_busy", done_o, 1'b0);
        for (int k = 0; k < ack_dly; k++) tick();
        check_eq("grant_hold", grant_o, exp_g);
        grant_ack_i = 1'b1;
        tick();
        grant_ack_i = 1'b0;
      end
      check_eq("end_gvalid", grant_valid_o, 1'b0);
      check_eq("end_grant", grant_o, 32'h0);
      check_eq("end_done", done_o, 1'b1);
      check_eq("end_ready", ready_o, 1'b1);
      tick();
      check_eq("done_pulse", done_o, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1; first_i = 4'd0; second_i = 4'd0;
    valid_i = 1'b0; grant_ack_i = 1'b0; exp_err = 1'b0;
    tick(); tick();
    rst_i = 1'b0;
    check_eq("rst_grant", grant_o, 32'h0);
    check_eq("rst_gvalid", grant_valid_o, 1'b0);
    check_eq("rst_done", done_o, 1'b0);
    check_eq("rst_err", err_o, 1'b0);
    check_eq("rst_ready", ready_o, 1'b1);

    run_pair(5, 2, 3);
    run_pair(12, 0, 1);
    run_pair(0, 0, 0);
    run_pair(7, 7, 2);
    run_pair(14, 3, 1);
    run_pair(0, 9, 0);
    run_pair(11, 1, 1);
    check_eq("err_sticky", err_o, 1'b1);

    // Producer holding a pair while the block is busy must not be taken twice.
    push_expected(4, 0);
    first_i = 4'd4; second_i = 4'd0; valid_i = 1'b1;
    tick();
    check_eq("hold_grant", grant_o, exp_q.pop_front());
    tick(); tick();
    check_eq("hold_ready", ready_o, 1'b0);
    grant_ack_i = 1'b1;
    valid_i = 1'b0;
    tick();
    grant_ack_i = 1'b0;
    check_eq("hold_done", done_o, 1'b1);
    tick();
    check_eq("hold_idle_gvalid", grant_valid_o, 1'b0);

    // Reset in the middle of a grant discards the pair.
    first_i = 4'd3; second_i = 4'd9; valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    check_eq("mid_grant", grant_o, 32'h004);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    exp_err = 1'b0;
    check_eq("mid_rst_grant", grant_o, 32'h0);
    check_eq("mid_rst_gvalid", grant_valid_o, 1'b0);
    check_eq("mid_rst_done", done_o, 1'b0);
    check_eq("mid_rst_ready", ready_o, 1'b1);
    check_eq("mid_rst_err", err_o, 1'b0);

    // Ack while idle has no effect.
    grant_ack_i = 1'b1;
    tick(); tick();
    grant_ack_i = 1'b0;
    check_eq("idle_ack_gvalid", grant_valid_o, 1'b0);
    check_eq("idle_ack_done", done_o, 1'b0);
    check_eq("idle_ack_ready", ready_o, 1'b1);

    for (int n = 0; n < 25; n++) begin
      run_pair(int'($urandom_range(15, 0)), int'($urandom_range(15, 0)),
               int'($urandom_range(2, 0)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
